wb_fifo_param: RTL

//  Parametrised Wishbone (pipelined) store-and-forward FIFO: accepts writes on a device port, forwards

---
 rtl/wb_fifo_pkg.sv | 19 +
 rtl/fifo_addr_gen.sv | 22 ++
 rtl/wb_fifo_param.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/wb_fifo_pkg.sv
// Shared types and sizing helpers for the Wishbone store-and-forward FIFO.
// Downstream FSM states plus level/depth width helpers.
package wb_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_ACK
  } fsm_e;

  function automatic int lvl_w(input int aw);
    return aw + 1;
  endfunction

  function automatic int depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/fifo_addr_gen.sv
// Wrapping FIFO pointer: advances by one on inc_i, wraps modulo 2**ADDR_WIDTH.
// Used twice by wb_fifo_param, once for the read and once for the write side.
module fifo_addr_gen
  import wb_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  inc_i,
  output logic [ADDR_WIDTH-1:0] ptr_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_o <= '0;
    end else if (inc_i) begin
      ptr_o <= ptr_o + 1'b1;
    end
  end

endmodule

// File: rtl/wb_fifo_param.sv
// Wishbone pipelined store-and-forward FIFO, one single-beat write per entry.
// Optional high-water mark tracking when WB_FIFO_PEAK_EN is defined.
module wb_fifo_param
  import wb_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  s_cyc_i,
  input  logic                  s_stb_i,
  input  logic                  s_we_i,
  input  logic [DATA_WIDTH-1:0] s_dat_i,
  output logic                  s_ack_o,
  output logic                  s_stall_o,
  output logic                  m_cyc_o,
  output logic                  m_stb_o,
  output logic                  m_we_o,
  output logic [DATA_WIDTH-1:0] m_dat_o,
  input  logic                  m_ack_i,
  input  logic                  m_stall_i,
  output logic [ADDR_WIDTH:0]   level_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  input  logic                  peak_clr_i,
  output logic [ADDR_WIDTH:0]   peak_o
);

  localparam int DEPTH = depth(ADDR_WIDTH);
  localparam int LW    = lvl_w(ADDR_WIDTH);

  typedef logic [LW-1:0] lvl_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  lvl_t                  level;
  fsm_e                  state;
  fsm_e                  state_nxt;
  logic                  full;
  logic                  empty;
  logic                  s_req;
  logic                  push;
  logic                  pop;

  assign full  = (level == lvl_t'(DEPTH));
  assign empty = (level == '0);
  assign s_req = s_cyc_i & s_stb_i & ~full;
  assign push  = s_req & s_we_i;
  assign pop   = (state == WAIT_ACK) & m_ack_i;

  assign s_stall_o      = full;
  assign level_o        = level;
  assign almost_full_o  = (level >= lvl_t'(AFULL_THRESH));
  assign almost_empty_o = (level <= lvl_t'(AEMPTY_THRESH));
  assign m_we_o         = 1'b1;
  assign m_dat_o        = mem[rd_ptr];

  fifo_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_wr_ptr (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .inc_i(push),
    .ptr_o(wr_ptr)
  );

  fifo_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_rd_ptr (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .inc_i(pop),
    .ptr_o(rd_ptr)
  );

  // Contents need no reset; level gates every read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= s_dat_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s_ack_o <= 1'b0;
    end else begin
      s_ack_o <= s_req;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      level <= '0;
    end else if (push && !pop) begin
      level <= level + 1'b1;
    end else if (pop && !push) begin
      level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (!empty) state_nxt = REQ;
      end
      REQ: begin
        if (!m_stall_i) state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (m_ack_i) begin
          if (level > lvl_t'(1) || push) state_nxt = REQ;
          else                           state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_cyc_o = 1'b0;
    m_stb_o = 1'b0;
    unique case (state)
      REQ: begin
        m_cyc_o = 1'b1;
        m_stb_o = 1'b1;
      end
      WAIT_ACK: begin
        m_cyc_o = 1'b1;
      end
      default: begin
        m_cyc_o = 1'b0;
        m_stb_o = 1'b0;
      end
    endcase
  end

`ifdef WB_FIFO_PEAK_EN
  lvl_t peak;

  // Clear reloads the current level rather than zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      peak <= '0;
    end else if (peak_clr_i) begin
      peak <= level;
    end else if (level > peak) begin
      peak <= level;
    end
  end

  assign peak_o = peak;
`else
  logic unused_peak_clr;

  assign unused_peak_clr = peak_clr_i;
  assign peak_o          = '0;
`endif

endmodule
